// File: rtl/mc_main_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I main controller.
// Holds the state enum, the opcodes and the datapath mux-select codes.
package mc_ctrl_pkg;

    localparam int unsigned OP_W    = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_RDATA  = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields in, selects and enables out.
// mem_ready exists only when MC_MAIN_CTRL_MEM_WAIT_EN is defined.
interface mc_main_ctrl_if;
    import mc_ctrl_pkg::*;

    logic [OP_W-1:0]    op;
    logic [F3_W-1:0]    funct3;
    logic               zero;
`ifdef MC_MAIN_CTRL_MEM_WAIT_EN
    logic               mem_ready;
`endif
    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic [SEL_W-1:0]   ResultSrc;
    logic [SEL_W-1:0]   ALUSrcA;
    logic [SEL_W-1:0]   ALUSrcB;
    logic [SEL_W-1:0]   ALUOp;
    logic [SEL_W-1:0]   ImmSrc;
    logic               RegWrite;
    logic               retire;
    logic               illegal;
    logic [STATE_W-1:0] state_o;

    modport master (
`ifdef MC_MAIN_CTRL_MEM_WAIT_EN
        input  mem_ready,
`endif
        input  op, funct3, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, retire, illegal, state_o
    );

    modport slave (
`ifdef MC_MAIN_CTRL_MEM_WAIT_EN
        output mem_ready,
`endif
        output op, funct3, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, ImmSrc, RegWrite, retire, illegal, state_o
    );

endinterface

// File: rtl/mc_main_ctrl_imm_src_dec.sv
// Combinational opcode -> immediate-format decoder, shared with the single-cycle decode path.
module mc_imm_src_dec
    import mc_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    output logic [SEL_W-1:0] imm_src_c
);

    always_comb begin
        imm_src_c = IMM_I;
        case (op)
            OP_STORE:  imm_src_c = IMM_S;
            OP_BRANCH: imm_src_c = IMM_B;
            OP_JAL:    imm_src_c = IMM_J;
            default:   imm_src_c = IMM_I;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle RV32I core (lw, sw, R/I ALU, jal, beq, bne).
// Optional MC_MAIN_CTRL_MEM_WAIT_EN stretches FETCH/MEMREAD/MEMWRITE until mem_ready.
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned RESET_STATE_FETCH = 1
) (
    input  logic           clk,
    input  logic           rst,
    mc_main_ctrl_if.master bus
);

    if (RESET_STATE_FETCH != 1) begin : g_bad_reset_state
        $error("mc_main_ctrl: RESET_STATE_FETCH must be 1");
    end

    state_e           state, state_nxt;
    logic             pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
    logic [SEL_W-1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic             mem_ready;
    logic [1:0]       unused_funct3;

`ifdef MC_MAIN_CTRL_MEM_WAIT_EN
    assign mem_ready = bus.mem_ready;
`else
    assign mem_ready = 1'b1;
`endif

    assign unused_funct3 = bus.funct3[2:1];

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Moore decode; reset shows FETCH selects with every enable held low.
    always_comb begin
        state_nxt  = S_FETCH;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        if (rst) begin
            result_src = RES_ALURES;
            alu_src_b  = SRCB_FOUR;
        end else begin
            case (state)
                S_FETCH: begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURES;
                    state_nxt  = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    case (bus.op)
                        OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                        OP_RTYPE:          state_nxt = S_EXECUTER;
                        OP_ITYPE:          state_nxt = S_EXECUTEI;
                        OP_JAL:            state_nxt = S_JAL;
                        OP_BRANCH:         state_nxt = S_BEQ;
                        default: begin
                            illegal   = 1'b1;
                            state_nxt = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    state_nxt = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    adr_src   = 1'b1;
                    state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
                end
                S_MEMWB: begin
                    result_src = RES_RDATA;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                S_MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    retire    = mem_ready;
                    state_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
                end
                S_EXECUTER: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_FUNCT;
                    state_nxt = S_ALUWB;
                end
                S_EXECUTEI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNCT;
                    state_nxt = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_JAL: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                    state_nxt = S_ALUWB;
                end
                S_BEQ: begin
                    // funct3[0] flips the sense of zero: beq vs bne
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_SUB;
                    pc_write  = bus.zero ^ bus.funct3[0];
                    retire    = 1'b1;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    assign bus.PCWrite   = pc_write;
    assign bus.AdrSrc    = adr_src;
    assign bus.MemWrite  = mem_write;
    assign bus.IRWrite   = ir_write;
    assign bus.ResultSrc = result_src;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ALUOp     = alu_op;
    assign bus.RegWrite  = reg_write;
    assign bus.retire    = retire;
    assign bus.illegal   = illegal;
    assign bus.state_o   = STATE_W'(state);

    mc_imm_src_dec u_imm_src_dec (
        .op        (bus.op),
        .imm_src_c (bus.ImmSrc)
    );

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Scoreboard bench for mc_main_ctrl: directed instruction sequences queue per-cycle expectations,
// a negedge monitor pops and compares state and every control output.
module tb_mc_main_ctrl;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_main_ctrl_if bus();

    mc_main_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc=00,RegWrite,retire,illegal}
    localparam logic [16:0] C_FETCH = 17'b1_0_0_1_10_00_10_00_00_0_0_0;
    localparam logic [16:0] C_RSTF  = 17'b0_0_0_0_10_00_10_00_00_0_0_0;
    localparam logic [16:0] C_DEC   = 17'b0_0_0_0_00_01_01_00_00_0_0_0;
    localparam logic [16:0] C_ILL   = 17'b0_0_0_0_00_01_01_00_00_0_0_1;
    localparam logic [16:0] C_MADR  = 17'b0_0_0_0_00_10_01_00_00_0_0_0;
    localparam logic [16:0] C_MRD   = 17'b0_1_0_0_00_00_00_00_00_0_0_0;
    localparam logic [16:0] C_MWB   = 17'b0_0_0_0_01_00_00_00_00_1_1_0;
    localparam logic [16:0] C_MWR   = 17'b0_1_1_0_00_00_00_00_00_0_1_0;
    localparam logic [16:0] C_EXR   = 17'b0_0_0_0_00_10_00_10_00_0_0_0;
    localparam logic [16:0] C_EXI   = 17'b0_0_0_0_00_10_01_10_00_0_0_0;
    localparam logic [16:0] C_ALUWB = 17'b0_0_0_0_00_00_00_00_00_1_1_0;
    localparam logic [16:0] C_JAL   = 17'b1_0_0_0_00_01_10_00_00_0_0_0;
    localparam logic [16:0] C_BRT   = 17'b1_0_0_0_00_10_00_01_00_0_1_0;
    localparam logic [16:0] C_BRN   = 17'b0_0_0_0_00_10_00_01_00_0_1_0;

    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_BAD = 7'b1110011;

    typedef struct {
        string       name;
        logic [20:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Queue the expected outputs for the current cycle, then advance one clock.
    task automatic cyc(input string name, input state_e st, input logic [16:0] o,
                       input logic [1:0] imm);
        exp_t e;
        e.name = name;
        e.v    = {4'(st), o | (17'(imm) << 3)};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t        e;
            logic [20:0] act;
            e   = exp_q.pop_front();
            act = {bus.state_o, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                   bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc,
                   bus.RegWrite, bus.retire, bus.illegal};
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                         e.name, act[20:17], act[16:0], e.v[20:17], e.v[16:0]);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        bus.op     = 7'd0;
        bus.funct3 = 3'd0;
        bus.zero   = 1'b0;
`ifdef MC_MAIN_CTRL_MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        @(posedge clk);
        #1;
        // reset held for three cycles
        cyc("rst0", S_FETCH, C_RSTF, 2'b00);
        cyc("rst1", S_FETCH, C_RSTF, 2'b00);
        cyc("rst2", S_FETCH, C_RSTF, 2'b00);
        rst = 1'b0;

        bus.op = OPC_LW;
        cyc("lw_fetch",  S_FETCH,   C_FETCH, 2'b00);
        cyc("lw_decode", S_DECODE,  C_DEC,   2'b00);
        cyc("lw_memadr", S_MEMADR,  C_MADR,  2'b00);
        cyc("lw_memrd",  S_MEMREAD, C_MRD,   2'b00);
        cyc("lw_memwb",  S_MEMWB,   C_MWB,   2'b00);

        bus.op = OPC_SW;
        cyc("sw_fetch",  S_FETCH,    C_FETCH, 2'b01);
        cyc("sw_decode", S_DECODE,   C_DEC,   2'b01);
        cyc("sw_memadr", S_MEMADR,   C_MADR,  2'b01);
        cyc("sw_memwr",  S_MEMWRITE, C_MWR,   2'b01);

        bus.op = OPC_R;
        cyc("r_fetch",  S_FETCH,    C_FETCH, 2'b00);
        cyc("r_decode", S_DECODE,   C_DEC,   2'b00);
        cyc("r_exec",   S_EXECUTER, C_EXR,   2'b00);
        cyc("r_aluwb",  S_ALUWB,    C_ALUWB, 2'b00);

        bus.op = OPC_I;
        cyc("i_fetch",  S_FETCH,    C_FETCH, 2'b00);
        cyc("i_decode", S_DECODE,   C_DEC,   2'b00);
        cyc("i_exec",   S_EXECUTEI, C_EXI,   2'b00);
        cyc("i_aluwb",  S_ALUWB,    C_ALUWB, 2'b00);

        bus.op = OPC_JAL;
        cyc("jal_fetch",  S_FETCH,  C_FETCH, 2'b11);
        cyc("jal_decode", S_DECODE, C_DEC,   2'b11);
        cyc("jal_jal",    S_JAL,    C_JAL,   2'b11);
        cyc("jal_aluwb",  S_ALUWB,  C_ALUWB, 2'b11);

        // all four beq/bne x zero combinations
        bus.op = OPC_BR;
        for (int k = 0; k < 4; k++) begin
            bus.funct3 = {2'b00, k[0]};
            bus.zero   = k[1];
            cyc("br_fetch",  S_FETCH,  C_FETCH, 2'b10);
            cyc("br_decode", S_DECODE, C_DEC,   2'b10);
            cyc("br_exec",   S_BEQ, (k[1] ^ k[0]) ? C_BRT : C_BRN, 2'b10);
        end
        bus.funct3 = 3'd0;
        bus.zero   = 1'b0;

        bus.op = OPC_BAD;
        cyc("ill_fetch",  S_FETCH,  C_FETCH, 2'b00);
        cyc("ill_decode", S_DECODE, C_ILL,   2'b00);
        cyc("ill_refetch", S_FETCH, C_FETCH, 2'b00);

        // reset landing in MEMWRITE suppresses the store
        bus.op = OPC_SW;
        cyc("swr_decode", S_DECODE, C_DEC,  2'b01);
        cyc("swr_memadr", S_MEMADR, C_MADR, 2'b01);
        rst = 1'b1;
        cyc("swr_rst", S_MEMWRITE, C_RSTF, 2'b01);
        rst = 1'b0;
        cyc("swr_fetch", S_FETCH, C_FETCH, 2'b01);

`ifdef MC_MAIN_CTRL_MEM_WAIT_EN
        bus.op = OPC_LW;
        cyc("lww_decode", S_DECODE, C_DEC,  2'b00);
        cyc("lww_memadr", S_MEMADR, C_MADR, 2'b00);
        bus.mem_ready = 1'b0;
        cyc("lww_hold0", S_MEMREAD, C_MRD, 2'b00);
        cyc("lww_hold1", S_MEMREAD, C_MRD, 2'b00);
        bus.mem_ready = 1'b1;
        cyc("lww_exit",  S_MEMREAD, C_MRD, 2'b00);
        cyc("lww_memwb", S_MEMWB,   C_MWB, 2'b00);
        cyc("lwr_fetch",  S_FETCH,  C_FETCH, 2'b00);
        cyc("lwr_decode", S_DECODE, C_DEC,   2'b00);
        cyc("lwr_memadr", S_MEMADR, C_MADR,  2'b00);
        bus.mem_ready = 1'b0;
        cyc("lwr_hold", S_MEMREAD, C_MRD, 2'b00);
        rst = 1'b1;
        cyc("lwr_rst", S_MEMREAD, C_RSTF, 2'b00);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        cyc("lwr_fetch2", S_FETCH, C_FETCH, 2'b00);
`endif

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
